// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit -- iterative radix-2 shift-add multiplier for the execute stage.
//
// Handles MUL/MLA (WIDTH-bit result) and UMULL/SMULL/UMLAL/SMLAL (2*WIDTH-bit
// result). Signed long multiplies work on operand magnitudes, and the product
// is negated at the end. One multiplier bit is retired per cycle, so every
// operation takes WIDTH CALC cycles plus one FINAL cycle.
//
// Ports:
//   clk, reset         clock (rising edge), synchronous active-high reset
//   start              request; only accepted in IDLE or DONE
//   long_mul           1 = 2*WIDTH result, 0 = WIDTH result
//   signed_mul         signed operands (long mode only)
//   accumulate         add {acc_hi,acc_lo} (long) or acc_lo (short)
//   a, b               multiplicand, multiplier
//   acc_hi, acc_lo     accumulator words
//   busy               high in CALC and FINAL (stalls the core)
//   done               one-cycle pulse; result/flags valid
//   result_hi/lo       result words (result_hi = 0 in short mode)
//   flag_n, flag_z     negative / zero flags of the reported result
// ---------------------------------------------------------------------------
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             long_mul,
    input  logic             signed_mul,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifts left
    logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifts right
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               long_q, long_d;
    logic               accum_q, accum_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [WIDTH-1:0]   result_lo_q, result_lo_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_z_q, flag_z_d;

    // Operand preparation and final-stage arithmetic.
    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] fin_prod, fin_sum, fin_res;
    logic               load;

    always_comb begin
        is_signed = signed_mul & long_mul;
        // |0x80..0| wraps to 0x80..0, which is the correct unsigned magnitude.
        a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

        fin_prod = sign_q ? (~prod_q + 1'b1) : prod_q;
        fin_sum  = fin_prod + (accum_q ? acc_q : '0);
        fin_res  = long_q ? fin_sum : {{WIDTH{1'b0}}, fin_sum[WIDTH-1:0]};

        load = start && ((state_q == IDLE) || (state_q == DONE));
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        long_d      = long_q;
        accum_d     = accum_q;
        sign_d      = sign_q;
        result_hi_d = result_hi_q;
        result_lo_d = result_lo_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = load ? CALC : IDLE;
            end
            CALC: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                result_hi_d = fin_res[2*WIDTH-1:WIDTH];
                result_lo_d = fin_res[WIDTH-1:0];
                flag_n_d    = long_q ? fin_res[2*WIDTH-1] : fin_res[WIDTH-1];
                flag_z_d    = (fin_res == '0);
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Capture a new request; inputs are not looked at again until done.
        if (load) begin
            count_d  = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            prod_d   = '0;
            acc_d    = long_mul ? {acc_hi, acc_lo} : {{WIDTH{1'b0}}, acc_lo};
            long_d   = long_mul;
            accum_d  = accumulate;
            sign_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            long_q      <= 1'b0;
            accum_q     <= 1'b0;
            sign_q      <= 1'b0;
            result_hi_q <= '0;
            result_lo_q <= '0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            long_q      <= long_d;
            accum_q     <= accum_d;
            sign_q      <= sign_d;
            result_hi_q <= result_hi_d;
            result_lo_q <= result_lo_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FINAL);
    assign done      = (state_q == DONE);
    assign result_hi = result_hi_q;
    assign result_lo = result_lo_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier in the execute stage, directly downstream of the main decoder.
- Started when the decoder flags a multiply (mult=1) and the condition check passes.
- Covers MUL/MLA (32-bit result) and UMULL/SMULL/UMLAL/SMLAL (64-bit result).
- Stalls the core via busy; returns result words plus N/Z flags for write-back through the reg_w3/reg_w1 paths.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- long_mul  in  1  1 = 64-bit result (xMULL/xMLAL), 0 = 32-bit (MUL/MLA).
- signed_mul  in  1  1 = signed operands (long mode only; ignored when long_mul=0).
- accumulate  in  1  1 = add {acc_hi,acc_lo} (long) or acc_lo (short).
- a  in  WIDTH  multiplicand (Rn/Rm field operand).
- b  in  WIDTH  multiplier.
- acc_hi  in  WIDTH  accumulate high word (long mode only).
- acc_lo  in  WIDTH  accumulate low word.
- busy  out  1  1 while in CALC or FINAL.
- done  out  1  one-cycle pulse; results valid.
- result_hi  out  WIDTH  high result word (0 in short mode).
- result_lo  out  WIDTH  low result word.
- flag_n  out  1  negative flag of result.
- flag_z  out  1  zero flag of result.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result_hi=0, result_lo=0, flag_n=0, flag_z=0; iteration counter=0. Reset has priority over everything, including mid-operation: any in-flight op is abandoned and no done pulse is produced.
- FSM states: IDLE, CALC, FINAL, DONE.
- IDLE, start=1: latch a, b, acc_hi, acc_lo, long_mul, signed_mul, accumulate; go to CALC with count=0. Input changes after this edge are ignored.
- Operand preparation at latch: if signed_mul&long_mul, store |a| and |b| and record sign = a[MSB]^b[MSB]; otherwise store raw values with sign=0.
- CALC: one iteration per cycle. If the multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH product register. Shift the multiplier right and the multiplicand left. After WIDTH iterations (count = WIDTH-1 at the edge) go to FINAL.
- FINAL (1 cycle):
  - If sign=1, two's-complement negate the 2*WIDTH product.
  - If accumulate, add the 2*WIDTH accumulator: long = {acc_hi,acc_lo}; short = zero-extended acc_lo. Arithmetic is modulo 2^(2*WIDTH).
  - Register results: long → result_hi/result_lo = upper/lower halves; short → result_lo = low WIDTH bits, result_hi = 0.
  - flag_n = MSB of result_hi (long) or result_lo (short). flag_z = 1 iff the full reported result is 0.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0.
  - start=1: latch new operands and go to CALC (back-to-back allowed).
  - Otherwise go to IDLE.
- Latency: with start sampled at edge n, results and flags update at edge n+WIDTH+1 and done=1 between edges n+WIDTH+1 and n+WIDTH+2 (33 edges for WIDTH=32).
- Result and flag outputs hold their values until the next FINAL or reset.
- busy=1 from edge n to edge n+WIDTH+1. start while busy is ignored and does not queue.
- Corner cases: a=0 or b=0 runs the full latency (no early termination). Signed 0x80000000 magnitude is 0x80000000 as unsigned; the result is correct.

Test Plan:
- UMULL a=0xFFFFFFFF, b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001, n=1, z=0; done exactly 33 edges after start, busy high for 33 cycles.
- SMULL a=0xFFFFFFFE (-2), b=3 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, n=1; SMULL a=0x80000000, b=0x80000000 → 0x40000000_00000000, n=0.
- MUL a=0x00010000, b=0x00010000 → result_lo=0, result_hi=0, z=1; MLA a=3, b=4, acc_lo=5 → result_lo=17, z=0, n=0.
- UMLAL a=0xFFFFFFFF, b=1, acc_hi=0, acc_lo=1 → result_hi=1, result_lo=0 (carry across words).
- start pulsed again at cycle 10 of an op → ignored, first result unchanged; start held high in DONE → second op begins immediately with no IDLE cycle.
- reset asserted at CALC cycle 15 → next edge busy=0, done=0, results=0, state IDLE; no done pulse; fresh start afterwards yields the correct product.
